fwd_mux_unit: RTL and testbench
===============================

Name: fwd_mux_unit

Overview:
- Parametrised operand-source selector for the pipelined MIPS core.
- Generalises the fixed per-field datapath muxes into one unit with NREAD read ports and an NSTAGE deep in-flight write scoreboard.
- Each read port is forwarded from the youngest producing stage, or falls back to the register-file value.
- Raises a D-stage stall when the required value cannot be produced in time.
- Sits between the D stage (register-file read) and the E/M/W pipeline registers.

Parameters:
WIDTH, 32, datapath word width
REGW, 5, register index width
NREAD, 2, number of operand read ports (rs, rt)
NSTAGE, 3, in-flight stages tracked (0=E, 1=M, 2=W)
TW, 2, width of Tnew/Tuse fields

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  D-stage instruction writes a register
in_a3  in  REGW  destination of D-stage instruction
in_tnew  in  TW  cycles after entering stage 0 until result exists
st_data  in  NSTAGE*WIDTH  result value currently held in each stage (slice s = stage s)
rd_en  in  NREAD  read port p actually uses its operand
rd_a  in  NREAD*REGW  source register per port
rd_tuse  in  NREAD*TW  cycles until port p's operand is consumed
rf_data  in  NREAD*WIDTH  register-file read data per port
fwd_data  out  NREAD*WIDTH  selected operand per port
fwd_hit  out  NREAD  port p is served from a stage
stall  out  1  hold PC/IF-ID, insert bubble into stage 0
stall_cnt  out  32  saturating count of stalled cycles

Behaviour:
- Scoreboard entry per stage s: valid, a3 (REGW), tnew (TW).
- Reset (reset low, asynchronous): all entries valid=0, a3=0, tnew=0; stall_cnt=0.
  - Outputs follow combinationally: fwd_data=rf_data, fwd_hit=0, stall=0.
- Clock edge, stage 0 load:
  - stall=1: stage 0 loads a bubble (valid=0, a3=0, tnew=0).
  - Otherwise stage 0 loads valid = in_valid && (in_a3 != 0), a3=in_a3, tnew=in_tnew.
- Clock edge, advance: stages 1..NSTAGE-1 load the previous stage with tnew = max(tnew-1, 0). The stage NSTAGE-1 entry retires.
- Advance always occurs; stall only blocks the D-side input, never the E/M/W progression.
- Port p match: lowest s with valid[s] && a3[s] == rd_a[p] && rd_a[p] != 0.
  - Lowest index = youngest producer, so it wins over older writes to the same register.
- Port p result:
  - No match: fwd_data = rf_data, fwd_hit=0.
  - Match with tnew==0: fwd_data = st_data[s], fwd_hit=1.
  - Match with tnew>0: fwd_data = rf_data (don't-care), fwd_hit=0, and hazard[p] = rd_en[p] && tnew > rd_tuse[p].
- stall = OR of hazard[p] over all ports. Purely combinational from scoreboard state and current inputs; zero-cycle latency.
- stall_cnt increments by 1 on each edge with stall=1 and saturates at 32'hFFFFFFFF.
- Register $0: never stored as valid, never matched. Reading $0 always returns rf_data.
- Last stage (W) entry is forwardable. This covers same-cycle write/read without relying on register-file internal bypass.
- Simultaneous events:
  - D instruction stalled while its own producer is in stage 0: bubble enters, producer advances with tnew decremented.
  - Hazard is re-evaluated next cycle.
- Reset asserted mid-stall: scoreboard clears immediately, stall drops in the same cycle.
- Forwarded hits may come from several stages for different ports in the same cycle; ports are independent.

Decomposition:
- Shared package/define file holds:
  - TW-wide Tnew/Tuse codes: T0=0, T1=1, T2=2.
  - Stage indices: ST_E=0, ST_M=1, ST_W=2.
  - The zero-register constant.
- The decoder supplies in_tnew and rd_tuse from these constants.
- One sub-module, fwd_port_sel, instantiated NREAD times: per-port priority match, data select, and hazard compare.
- The top level holds the scoreboard shift register, the stall OR, and stall_cnt.

Test Plan:
1. Reset low for 2 cycles with rd_a={5,6}, rf_data={AAAA0000,BBBB0000} -> fwd_data equals rf_data, fwd_hit=00, stall=0, stall_cnt=0.
2. addu $8 (in_tnew=1), then next instruction reads $8 with tuse=1 -> stage 0 entry has tnew=1 ≤ tuse, so no stall. One cycle later the entry is in stage 1 with tnew=0 and st_data[1]=0x1234 -> fwd_data[p]=0x1234, fwd_hit=1.
3. lw $9 (tnew=2), next instruction beq reads $9 with tuse=0 -> stall=1 for 2 cycles, stall_cnt=2. Then the W-stage entry with st_data[2]=0xCAFE is forwarded and stall=0.
4. $10 written in stages 0 (tnew=0, data 0x11) and 2 (data 0x22), port reads $10 -> 0x11 (youngest wins).
5. in_a3=0 with in_valid=1, later read $0 with rf_data=0 -> never matches, fwd_hit=0, fwd_data=0, no stall.
6. Hazard active (stall=1), then reset pulsed low mid-cycle -> stall and fwd_hit drop asynchronously, stall_cnt=0. After release, no stale matches.

Source files
------------

// File: rtl/fwd_mux_unit_pkg.sv
// Shared constants for the operand forwarding unit: Tnew/Tuse codes, stage indices
// and the hard-wired zero register.
package fwd_mux_unit_pkg;

   localparam logic [1:0] T0 = 2'd0;
   localparam logic [1:0] T1 = 2'd1;
   localparam logic [1:0] T2 = 2'd2;

   localparam int unsigned ST_E = 0;
   localparam int unsigned ST_M = 1;
   localparam int unsigned ST_W = 2;

   localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/fwd_port_sel.sv
// One operand read port: picks the youngest in-flight producer of rd_a, forwards its
// data when ready, and flags a hazard when the value arrives too late for its consumer.
module fwd_port_sel
   import fwd_mux_unit_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned REGW   = 5,
   parameter int unsigned NSTAGE = 3,
   parameter int unsigned TW     = 2
) (
   input  logic [NSTAGE-1:0]       sb_valid,
   input  logic [NSTAGE*REGW-1:0]  sb_a3,
   input  logic [NSTAGE*TW-1:0]    sb_tnew,
   input  logic [NSTAGE*WIDTH-1:0] st_data,
   input  logic                    rd_en,
   input  logic [REGW-1:0]         rd_a,
   input  logic [TW-1:0]           rd_tuse,
   input  logic [WIDTH-1:0]        rf_data,
   output logic [WIDTH-1:0]        fwd_data,
   output logic                    fwd_hit,
   output logic                    hazard
);

   logic             match;
   logic [TW-1:0]    m_tnew;
   logic [WIDTH-1:0] m_data;

   always_comb begin
      match  = 1'b0;
      m_tnew = '0;
      m_data = '0;
      // Walk oldest to youngest so the youngest producer's match is the one left standing.
      for (int s = NSTAGE - 1; s >= 0; s--) begin
         if (sb_valid[s] && (sb_a3[s*REGW +: REGW] == rd_a) && (rd_a != REGW'(ZERO_REG))) begin
            match  = 1'b1;
            m_tnew = sb_tnew[s*TW +: TW];
            m_data = st_data[s*WIDTH +: WIDTH];
         end
      end
   end

   assign fwd_hit  = match && (m_tnew == '0);
   assign fwd_data = fwd_hit ? m_data : rf_data;
   assign hazard   = match && rd_en && (m_tnew > rd_tuse);

endmodule

// File: rtl/fwd_mux_unit.sv
// Operand-source selector: in-flight write scoreboard for E/M/W, per-port forwarding
// select, D-stage stall generation and a saturating stall-cycle counter.
module fwd_mux_unit
   import fwd_mux_unit_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned REGW   = 5,
   parameter int unsigned NREAD  = 2,
   parameter int unsigned NSTAGE = 3,
   parameter int unsigned TW     = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [REGW-1:0]         in_a3,
   input  logic [TW-1:0]           in_tnew,
   input  logic [NSTAGE*WIDTH-1:0] st_data,
   input  logic [NREAD-1:0]        rd_en,
   input  logic [NREAD*REGW-1:0]   rd_a,
   input  logic [NREAD*TW-1:0]     rd_tuse,
   input  logic [NREAD*WIDTH-1:0]  rf_data,
   output logic [NREAD*WIDTH-1:0]  fwd_data,
   output logic [NREAD-1:0]        fwd_hit,
   output logic                    stall,
   output logic [31:0]             stall_cnt
);

   logic [NSTAGE-1:0]           sb_valid;
   logic [NSTAGE-1:0][REGW-1:0] sb_a3;
   logic [NSTAGE-1:0][TW-1:0]   sb_tnew;
   logic [NREAD-1:0]            hazard;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sb_valid  <= '0;
         sb_a3     <= '0;
         sb_tnew   <= '0;
         stall_cnt <= '0;
      end else begin
         if (stall) begin
            sb_valid[ST_E] <= 1'b0;
            sb_a3[ST_E]    <= '0;
            sb_tnew[ST_E]  <= '0;
         end else begin
            sb_valid[ST_E] <= in_valid && (in_a3 != REGW'(ZERO_REG));
            sb_a3[ST_E]    <= in_a3;
            sb_tnew[ST_E]  <= in_tnew;
         end
         // E/M/W always advance; a stall only holds the D side.
         for (int s = 1; s < NSTAGE; s++) begin
            sb_valid[s] <= sb_valid[s-1];
            sb_a3[s]    <= sb_a3[s-1];
            sb_tnew[s]  <= (sb_tnew[s-1] == '0) ? '0 : sb_tnew[s-1] - TW'(1);
         end
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end

   for (genvar p = 0; p < NREAD; p++) begin : g_port
      fwd_port_sel #(
         .WIDTH  (WIDTH),
         .REGW   (REGW),
         .NSTAGE (NSTAGE),
         .TW     (TW)
      ) u_sel (
         .sb_valid (sb_valid),
         .sb_a3    (sb_a3),
         .sb_tnew  (sb_tnew),
         .st_data  (st_data),
         .rd_en    (rd_en[p]),
         .rd_a     (rd_a[p*REGW +: REGW]),
         .rd_tuse  (rd_tuse[p*TW +: TW]),
         .rf_data  (rf_data[p*WIDTH +: WIDTH]),
         .fwd_data (fwd_data[p*WIDTH +: WIDTH]),
         .fwd_hit  (fwd_hit[p]),
         .hazard   (hazard[p])
      );
   end

   assign stall = |hazard;

endmodule

// File: tb/tb_fwd_mux_unit.sv
// Self-checking bench for fwd_mux_unit: directed scenarios plus randomized traffic
// compared against an instruction-history reference model.
module tb_fwd_mux_unit;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [4:0]  in_a3;
   logic [1:0]  in_tnew;
   logic [95:0] st_data;
   logic [1:0]  rd_en;
   logic [9:0]  rd_a;
   logic [3:0]  rd_tuse;
   logic [63:0] rf_data;
   logic [63:0] fwd_data;
   logic [1:0]  fwd_hit;
   logic        stall;
   logic [31:0] stall_cnt;

   int    n_tests = 0;
   int    n_fail  = 0;
   string phase   = "init";

   // Model: what instruction entered stage 0 at each of the last three edges.
   bit          m_valid[3];
   int          m_a3[3];
   int          m_tnew0[3];
   longint      m_cnt;

   int          pool[6] = '{0, 1, 2, 3, 8, 9};

   fwd_mux_unit dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_a3     (in_a3),
      .in_tnew   (in_tnew),
      .st_data   (st_data),
      .rd_en     (rd_en),
      .rd_a      (rd_a),
      .rd_tuse   (rd_tuse),
      .rf_data   (rf_data),
      .fwd_data  (fwd_data),
      .fwd_hit   (fwd_hit),
      .stall     (stall),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %h expected %h", phase, tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int s = 0; s < 3; s++) begin
         m_valid[s] = 1'b0;
         m_a3[s]    = 0;
         m_tnew0[s] = 0;
      end
      m_cnt = 0;
   endtask

   // An instruction loaded with Tnew t is ready after t cycles; s stages later it
   // needs max(t - s, 0) more cycles.
   task automatic model_eval(output logic [63:0] ed, output logic [1:0] eh, output logic es);
      es = 1'b0;
      for (int p = 0; p < 2; p++) begin
         int ra;
         int found;
         int rem;
         ra    = int'(rd_a[p*5 +: 5]);
         found = -1;
         for (int s = 0; s < 3; s++)
            if (found < 0 && m_valid[s] && m_a3[s] == ra && ra != 0) found = s;
         ed[p*32 +: 32] = rf_data[p*32 +: 32];
         eh[p]          = 1'b0;
         if (found >= 0) begin
            rem = m_tnew0[found] - found;
            if (rem < 0) rem = 0;
            if (rem == 0) begin
               ed[p*32 +: 32] = st_data[found*32 +: 32];
               eh[p]          = 1'b1;
            end else if (rd_en[p] && rem > int'(rd_tuse[p*2 +: 2])) begin
               es = 1'b1;
            end
         end
      end
   endtask

   task automatic model_advance(input logic es);
      for (int s = 2; s > 0; s--) begin
         m_valid[s] = m_valid[s-1];
         m_a3[s]    = m_a3[s-1];
         m_tnew0[s] = m_tnew0[s-1];
      end
      m_valid[0] = !es && in_valid && (in_a3 != 5'd0);
      m_a3[0]    = es ? 0 : int'(in_a3);
      m_tnew0[0] = es ? 0 : int'(in_tnew);
      if (es && m_cnt < 64'hFFFF_FFFF) m_cnt++;
   endtask

   task automatic step();
      logic [63:0] ed;
      logic [1:0]  eh;
      logic        es;
      #1;
      model_eval(ed, eh, es);
      check("data", fwd_data, ed);
      check("hit", {62'd0, fwd_hit}, {62'd0, eh});
      check("stall", {63'd0, stall}, {63'd0, es});
      check("cnt", {32'd0, stall_cnt}, m_cnt);
      @(posedge clk);
      model_advance(es);
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_a3    = '0;
      in_tnew  = '0;
      rd_en    = '0;
      rd_tuse  = '0;
   endtask

   task automatic do_reset();
      idle();
      rd_a    = {5'd6, 5'd5};
      rf_data = {32'hBBBB0000, 32'hAAAA0000};
      st_data = {32'h3, 32'h2, 32'h1};
      reset   = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      #1;
      check("rst.data", fwd_data, 64'hBBBB0000_AAAA0000);
      check("rst.hit", {62'd0, fwd_hit}, 64'd0);
      check("rst.stall", {63'd0, stall}, 64'd0);
      check("rst.cnt", {32'd0, stall_cnt}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      rd_a    = '0;
      rf_data = '0;
      st_data = '0;
      model_clear();

      phase = "t1";
      do_reset();

      // Load-use: lw $9 (Tnew 2) then beq reading $9 at Tuse 0.
      phase = "t3";
      do_reset();
      in_valid = 1'b1; in_a3 = 5'd9; in_tnew = 2'd2;
      step();
      idle();
      rd_a = {5'd0, 5'd9}; rd_en = 2'b01; rd_tuse = {2'd0, 2'd0};
      st_data = {32'hCAFE, 32'h5555, 32'h6666};
      step();
      step();
      #1;
      check("t3.stall", {63'd0, stall}, 64'd0);
      check("t3.hit", {63'd0, fwd_hit[0]}, 64'd1);
      check("t3.data", {32'd0, fwd_data[31:0]}, 64'hCAFE);
      check("t3.cnt", {32'd0, stall_cnt}, 64'd2);
      step();

      // addu $8 (Tnew 1) followed by a Tuse-1 read on port 1.
      phase = "t2";
      do_reset();
      in_valid = 1'b1; in_a3 = 5'd8; in_tnew = 2'd1;
      step();
      idle();
      rd_a = {5'd8, 5'd0}; rd_en = 2'b10; rd_tuse = {2'd1, 2'd0};
      #1;
      check("t2.nostall", {63'd0, stall}, 64'd0);
      check("t2.nohit", {62'd0, fwd_hit}, 64'd0);
      step();
      st_data = {32'h7777, 32'h1234, 32'h9999};
      #1;
      check("t2.hit", {62'd0, fwd_hit}, 64'd2);
      check("t2.data", {32'd0, fwd_data[63:32]}, 64'h1234);
      step();

      // Two producers of $10: youngest (stage 0) must win over stage 2.
      phase = "t4";
      do_reset();
      in_valid = 1'b1; in_tnew = 2'd0;
      in_a3 = 5'd10; step();
      in_a3 = 5'd11; step();
      in_a3 = 5'd10; step();
      idle();
      rd_a = {5'd0, 5'd10}; rd_en = 2'b01;
      st_data = {32'h22, 32'h33, 32'h11};
      #1;
      check("t4.data", {32'd0, fwd_data[31:0]}, 64'h11);
      check("t4.hit", {63'd0, fwd_hit[0]}, 64'd1);
      step();

      // Writes to $0 are never tracked.
      phase = "t5";
      do_reset();
      in_valid = 1'b1; in_a3 = 5'd0; in_tnew = 2'd2;
      step();
      idle();
      rd_a = {5'd0, 5'd0}; rd_en = 2'b11; rf_data = '0;
      #1;
      check("t5.hit", {62'd0, fwd_hit}, 64'd0);
      check("t5.data", fwd_data, 64'd0);
      check("t5.stall", {63'd0, stall}, 64'd0);
      step();

      // Reset asserted mid-cycle while a hazard is active.
      phase = "t6";
      do_reset();
      in_valid = 1'b1; in_a3 = 5'd9; in_tnew = 2'd2;
      step();
      idle();
      rd_a = {5'd0, 5'd9}; rd_en = 2'b01;
      #2;
      check("t6.pre", {63'd0, stall}, 64'd1);
      reset = 1'b0;
      model_clear();
      #1;
      check("t6.stall", {63'd0, stall}, 64'd0);
      check("t6.hit", {62'd0, fwd_hit}, 64'd0);
      check("t6.cnt", {32'd0, stall_cnt}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      step();
      step();

      phase = "rnd";
      for (int i = 0; i < 600; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_a3    = 5'(pool[$urandom_range(0, 5)]);
         in_tnew  = 2'($urandom_range(0, 2));
         rd_a     = {5'(pool[$urandom_range(0, 5)]), 5'(pool[$urandom_range(0, 5)])};
         rd_en    = 2'($urandom_range(0, 3));
         rd_tuse  = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
         st_data  = {$urandom, $urandom, $urandom};
         rf_data  = {$urandom, $urandom};
         if ($urandom_range(0, 59) == 0) begin
            #2;
            reset = 1'b0;
            model_clear();
            #1;
            check("rnd.rst.stall", {63'd0, stall}, 64'd0);
            check("rnd.rst.hit", {62'd0, fwd_hit}, 64'd0);
            check("rnd.rst.cnt", {32'd0, stall_cnt}, 64'd0);
            @(negedge clk);
            reset = 1'b1;
         end else begin
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
